instruction_fetch: RTL and testbench

- Fetch stage of the MIPS-lite pipeline. It holds the program counter and drives the word address into the combinational instruction memory, which sits directly downstream of it.
- It captures the returned instruction into the IF/ID pipeline register for decode.
- It handles sequential advance, branch/jump redirect, stall (hold) and flush (bubble insertion).
- It provides a retired-fetch counter and a sticky misaligned-target flag.

---
 rtl/instruction_fetch_if.sv | 38 +++
 rtl/instruction_fetch.sv | 105 ++++++++++
 tb/tb_instruction_fetch.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle.
// Groups the hazard/redirect controls, the instruction-memory port and the
// IF/ID register outputs of instruction_fetch.
//   master : environment side (hazard unit, branch/jump logic, instruction memory)
//   slave  : fetch-stage side (instruction_fetch)
interface instruction_fetch_if #(
   parameter int unsigned IM_ADDR_W = 10
);
   logic                 stall;
   logic                 flush;
   logic                 branch_taken;
   logic [31:0]          branch_target;
   logic                 jump;
   logic [31:0]          jump_target;
   logic [IM_ADDR_W-1:0] im_addr;
   logic [31:0]          im_instruction;
   logic [31:0]          pc;
   logic                 if_id_valid;
   logic [31:0]          if_id_instruction;
   logic [31:0]          if_id_pc;
   logic [31:0]          if_id_pc_plus4;
   logic [31:0]          fetch_count;
   logic                 target_misaligned;

   modport master (
      output stall, flush, branch_taken, branch_target, jump, jump_target,
             im_instruction,
      input  im_addr, pc, if_id_valid, if_id_instruction, if_id_pc,
             if_id_pc_plus4, fetch_count, target_misaligned
   );

   modport slave (
      input  stall, flush, branch_taken, branch_target, jump, jump_target,
             im_instruction,
      output im_addr, pc, if_id_valid, if_id_instruction, if_id_pc,
             if_id_pc_plus4, fetch_count, target_misaligned
   );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS-lite instruction fetch stage.
// Holds the PC, addresses the combinational instruction memory and captures
// the returned word into the IF/ID register. Supports sequential advance,
// jump/branch redirect, stall and flush, plus a retired-fetch counter and a
// sticky misaligned-redirect flag.
// Ports:
//   clk  : system clock, rising-edge state updates
//   rst  : asynchronous active-high reset
//   ifb  : instruction_fetch_if.slave
//          in  : stall, flush, branch_taken/branch_target, jump/jump_target,
//                im_instruction
//          out : im_addr, pc, if_id_valid, if_id_instruction, if_id_pc,
//                if_id_pc_plus4, fetch_count, target_misaligned
module instruction_fetch #(
   parameter int unsigned IM_ADDR_W = 10,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   instruction_fetch_if.slave    ifb
);

   logic [31:0] pc_q,      pc_d;
   logic        valid_q,   valid_d;
   logic [31:0] instr_q,   instr_d;
   logic [31:0] ipc_q,     ipc_d;
   logic [31:0] ipc4_q,    ipc4_d;
   logic [31:0] count_q,   count_d;
   logic        mis_q,     mis_d;

   logic [31:0] pc_plus4;
   logic [31:0] target;

   assign pc_plus4 = pc_q + 32'd4;
   // Jump wins over branch when both are presented.
   assign target   = ifb.jump ? ifb.jump_target : ifb.branch_target;

   always_comb begin
      pc_d    = pc_q;
      valid_d = valid_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      ipc4_d  = ipc4_q;
      count_d = count_q;
      mis_d   = mis_q;

      if (ifb.stall) begin
         // Everything holds; redirects and flush are dropped this cycle.
      end else if (ifb.jump || ifb.branch_taken) begin
         pc_d    = {target[31:2], 2'b00};
         valid_d = 1'b0;
         instr_d = NOP_WORD;
         ipc_d   = '0;
         ipc4_d  = '0;
         if (target[1:0] != 2'b00) begin
            mis_d = 1'b1;
         end
      end else if (ifb.flush) begin
         pc_d    = pc_plus4;
         valid_d = 1'b0;
         instr_d = NOP_WORD;
         ipc_d   = '0;
         ipc4_d  = '0;
      end else begin
         pc_d    = pc_plus4;
         valid_d = 1'b1;
         instr_d = ifb.im_instruction;
         ipc_d   = pc_q;
         ipc4_d  = pc_plus4;
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         instr_q <= NOP_WORD;
         ipc_q   <= '0;
         ipc4_q  <= '0;
         count_q <= '0;
         mis_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         ipc4_q  <= ipc4_d;
         count_q <= count_d;
         mis_q   <= mis_d;
      end
   end

   // Upper PC bits are ignored: the word address wraps modulo memory size.
   assign ifb.im_addr           = pc_q[IM_ADDR_W+1:2];
   assign ifb.pc                = pc_q;
   assign ifb.if_id_valid       = valid_q;
   assign ifb.if_id_instruction = instr_q;
   assign ifb.if_id_pc          = ipc_q;
   assign ifb.if_id_pc_plus4    = ipc4_q;
   assign ifb.fetch_count       = count_q;
   assign ifb.target_misaligned = mis_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
   localparam int unsigned AW    = 10;
   localparam int unsigned WORDS = 1 << AW;
   localparam logic [31:0] RPC   = 32'h0000_0000;
   localparam logic [31:0] NOP   = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   instruction_fetch_if #(.IM_ADDR_W(AW)) bus ();

   logic [31:0] mem [0:WORDS-1];
   assign bus.im_instruction = mem[bus.im_addr];

   instruction_fetch #(
      .IM_ADDR_W (AW),
      .RESET_PC  (RPC),
      .NOP_WORD  (NOP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .ifb (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference state
   logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
   logic        m_valid, m_mis;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [31:0] waddr;
      waddr = (m_pc / 4) % WORDS;
      chk("pc",          bus.pc,                    m_pc);
      chk("im_addr",     32'(bus.im_addr),          waddr);
      chk("valid",       32'(bus.if_id_valid),      32'(m_valid));
      chk("instr",       bus.if_id_instruction,     m_instr);
      chk("if_id_pc",    bus.if_id_pc,              m_ipc);
      chk("if_id_pc4",   bus.if_id_pc_plus4,        m_ipc4);
      chk("fetch_count", bus.fetch_count,           m_cnt);
      chk("misaligned",  32'(bus.target_misaligned), 32'(m_mis));
   endtask

   task automatic model_reset();
      m_pc = RPC; m_valid = 1'b0; m_instr = NOP;
      m_ipc = 32'd0; m_ipc4 = 32'd0; m_cnt = 32'd0; m_mis = 1'b0;
   endtask

   task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt);
      bus.stall = s; bus.flush = f; bus.branch_taken = b; bus.branch_target = bt;
      bus.jump = j; bus.jump_target = jt;
   endtask

   // One rising edge: advance the reference from the inputs presented, then compare.
   task automatic step();
      logic [31:0] t;
      @(posedge clk);
      if (bus.stall) begin
      end else if (bus.jump || bus.branch_taken) begin
         t = bus.jump ? bus.jump_target : bus.branch_target;
         if (t % 4 != 0) m_mis = 1'b1;
         m_pc = t - (t % 4);
         m_valid = 1'b0; m_instr = NOP; m_ipc = 0; m_ipc4 = 0;
      end else if (bus.flush) begin
         m_pc = m_pc + 4;
         m_valid = 1'b0; m_instr = NOP; m_ipc = 0; m_ipc4 = 0;
      end else begin
         m_instr = mem[(m_pc / 4) % WORDS];
         m_ipc   = m_pc;
         m_ipc4  = m_pc + 4;
         m_pc    = m_pc + 4;
         m_valid = 1'b1;
         m_cnt   = m_cnt + 1;
      end
      #1;
      check_all();
   endtask

   // Async reset applied between edges; checked before any clock edge occurs.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      rst = 1'b0;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
      mem[0] = 32'h2001_0005;
      mem[1] = 32'h2002_0007;
      mem[2] = 32'h0022_1820;
      mem[3] = 32'hAC03_0000;
      #1;
      model_reset();
      check_all();
      rst = 1'b0;

      // Sequential fetch
      for (int i = 0; i < 4; i++) step();
      chk("seq_pc", bus.pc, 32'h10);
      chk("seq_cnt", bus.fetch_count, 32'd4);
      chk("seq_last", bus.if_id_instruction, 32'hAC03_0000);

      // Stall hold at pc=0x8
      do_reset();
      step(); step();
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step();
      chk("stall_pc", bus.pc, 32'h8);
      chk("stall_ipc", bus.if_id_pc, 32'h4);
      drive(0, 0, 0, 0, 0, 0);
      step();
      chk("unstall_instr", bus.if_id_instruction, 32'h0022_1820);

      // Branch redirect at pc=0xC
      drive(0, 0, 1, 32'h40, 0, 0);
      step();
      chk("br_pc", bus.pc, 32'h40);
      drive(0, 0, 0, 0, 0, 0);
      step();
      chk("br_ipc", bus.if_id_pc, 32'h40);

      // Jump beats branch; misaligned target
      drive(0, 0, 1, 32'h20, 1, 32'h83);
      step();
      chk("jmp_pc", bus.pc, 32'h80);
      chk("jmp_mis", 32'(bus.target_misaligned), 32'd1);
      drive(0, 0, 0, 0, 0, 0);
      step(); step();

      // Flush under stall, then flush alone at pc=0x10
      drive(0, 0, 0, 0, 1, 32'h10);
      step();
      drive(1, 1, 0, 0, 0, 0);
      step();
      drive(0, 1, 0, 0, 0, 0);
      step();
      chk("flush_pc", bus.pc, 32'h14);

      // Redirect ignored while stalled
      drive(1, 0, 1, 32'h100, 1, 32'h200);
      step();

      // Async reset mid-cycle at pc=0x24
      drive(0, 0, 0, 0, 1, 32'h24);
      step();
      drive(0, 0, 0, 0, 0, 0);
      #2;
      do_reset();
      step();

      // PC wrap from 0xFFFF_FFFC
      drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      step();
      chk("wrap_addr_hi", 32'(bus.im_addr), 32'h3FF);
      drive(0, 0, 0, 0, 0, 0);
      step();
      chk("wrap_pc", bus.pc, 32'h0);
      chk("wrap_pc4", bus.if_id_pc_plus4, 32'h0);

      // Randomized traffic
      do_reset();
      for (int n = 0; n < 400; n++) begin
         logic [31:0] bt, jt;
         bt = ($urandom % 4 == 0) ? $urandom : $urandom_range(0, 8191);
         jt = ($urandom % 4 == 0) ? $urandom : $urandom_range(0, 8191);
         drive(($urandom % 6) == 0, ($urandom % 7) == 0, ($urandom % 9) == 0, bt,
               ($urandom % 11) == 0, jt);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
